stoch_decode: RTL and testbench

- Downstream stage of the stochastic arithmetic operators (div/mult/add). Converts a signed stochastic bitstream pair back to a binary fixed-point value.
- Counts positive-stream ones minus negative-stream ones over a programmable window of 2^WINDOW_LOG2 cycles.
- Presents the signed result on a valid/ready handshake for the binary domain (debug readout, deterministic ops).

---
 rtl/stoch_pkg.sv | 24 ++
 rtl/stoch_decode.sv | 128 ++++++++++++
 tb/tb_stoch_decode.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stoch_pkg.sv
// ============================================================================
// Module      : stoch_pkg
// Description : Shared types and helpers for the stochastic-to-binary decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stoch_pkg;

    // Decoder control states
    typedef enum logic [1:0] {
        STOCH_DEC_IDLE  = 2'd0,
        STOCH_DEC_ACCUM = 2'd1,
        STOCH_DEC_DONE  = 2'd2
    } stoch_dec_state_e;

    // Signed result width able to hold -2^W .. +2^W
    function automatic int stoch_val_width(input int window_log2);
        return window_log2 + 2;
    endfunction

endpackage : stoch_pkg

`default_nettype wire

// File: rtl/stoch_decode.sv
// ============================================================================
// Module      : stoch_decode
// Description : Decodes a signed stochastic bitstream pair (x_p / x_m) into a
//               signed binary count over a window of 2^WINDOW_LOG2 samples and
//               presents it on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stoch_decode
    import stoch_pkg::*;
#(
    parameter  int WINDOW_LOG2 = 8,
    localparam int VAL_WIDTH   = stoch_val_width(WINDOW_LOG2)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        start,
    input  logic                        x_p,
    input  logic                        x_m,
    output logic                        busy,
    output logic signed [VAL_WIDTH-1:0] value,
    output logic                        valid,
    input  logic                        ready
);

    stoch_dec_state_e               state_q;
    logic [WINDOW_LOG2-1:0]         cnt_q;
    logic signed [VAL_WIDTH-1:0]    acc_q;
    logic signed [VAL_WIDTH-1:0]    acc_d;
    logic signed [VAL_WIDTH-1:0]    delta_d;
    logic signed [VAL_WIDTH-1:0]    value_q;
    logic                           busy_q;
    logic                           valid_q;
    logic                           xp_q;
    logic                           xm_q;
    // Set on window entry: the sample register still holds a bit taken before
    // the window opened, so the first ACCUM edge only primes the pipeline.
    logic                           prime_q;

    // Input sample register; keeps the stochastic inputs off any output path
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            xp_q <= 1'b0;
            xm_q <= 1'b0;
        end else begin
            xp_q <= x_p;
            xm_q <= x_m;
        end
    end

    // Per-sample contribution: +1, -1, or 0 when both or neither stream fire
    always_comb begin
        delta_d = '0;
        case ({xp_q, xm_q})
            2'b10:   delta_d = VAL_WIDTH'(1);
            2'b01:   delta_d = {VAL_WIDTH{1'b1}};
            default: delta_d = '0;
        endcase
        acc_d = acc_q + delta_d;
    end

    // Window control FSM with accumulator, counter and registered outputs
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= STOCH_DEC_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            prime_q <= 1'b0;
        end else begin
            case (state_q)
                STOCH_DEC_IDLE: begin
                    if (start) begin
                        state_q <= STOCH_DEC_ACCUM;
                        busy_q  <= 1'b1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        prime_q <= 1'b1;
                    end
                end
                STOCH_DEC_ACCUM: begin
                    if (prime_q) begin
                        prime_q <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + WINDOW_LOG2'(1);
                        // Last sample of the window: publish including it
                        if (cnt_q == {WINDOW_LOG2{1'b1}}) begin
                            value_q <= acc_d;
                            state_q <= STOCH_DEC_DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                        end
                    end
                end
                STOCH_DEC_DONE: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        if (start) begin
                            state_q <= STOCH_DEC_ACCUM;
                            busy_q  <= 1'b1;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            prime_q <= 1'b1;
                        end else begin
                            state_q <= STOCH_DEC_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= STOCH_DEC_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign value = value_q;

endmodule : stoch_decode

`default_nettype wire

// File: tb/tb_stoch_decode.sv
// ============================================================================
// Module      : tb_stoch_decode
// Description : Self-checking bench for stoch_decode with WINDOW_LOG2 = 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stoch_decode;

    localparam int WL  = 4;
    localparam int VW  = WL + 2;
    localparam int WIN = 1 << WL;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic                 start;
    logic                 x_p;
    logic                 x_m;
    logic                 busy;
    logic signed [VW-1:0] value;
    logic                 valid;
    logic                 ready;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int mode;
        int exp;
    } vec_t;

    vec_t vecs [6];

    stoch_decode #(.WINDOW_LOG2(WL)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .x_p   (x_p),
        .x_m   (x_m),
        .busy  (busy),
        .value (value),
        .valid (valid),
        .ready (ready)
    );

    always #5 CLK = ~CLK;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (act timeout, req finish)");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Stream pattern: returns {x_p, x_m} for sample i of a given mode
    function automatic logic [1:0] pat(input int mode, input int i);
        case (mode)
            0: return 2'b10;                          // all positive
            1: return (i % 2 == 0) ? 2'b10 : 2'b00;   // p alternating 1,0
            2: return 2'b01;                          // all negative
            3: return 2'b11;                          // both every cycle
            4: return (i < 3) ? 2'b10 : 2'b01;        // 3 positive, 13 negative
            5: return (i % 2 == 0) ? 2'b11 : 2'b10;   // p always, m alternating
            default: return 2'b00;
        endcase
    endfunction

    // Starts a window from IDLE, feeds 16 samples, checks latency and result.
    // pulse_at >= 0 raises start on that sample cycle (must be ignored).
    task automatic run_window(input int mode, input int exp, input int pulse_at);
        int busy_bad;
        busy_bad = 0;
        start = 1'b1;
        tick();                                  // edge E0
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        for (int i = 0; i < WIN; i++) begin
            {x_p, x_m} = pat(mode, i);
            start = (i == pulse_at);
            tick();
            if (busy !== 1'b1) busy_bad++;
        end
        start = 1'b0;
        // Off-window garbage: must not leak into the result
        x_p = 1'b0;
        x_m = 1'b1;
        check("busy_in_window", busy_bad, 0);
        check("valid_early", int'(valid), 0);    // edge E0+16
        tick();                                  // edge E0+17
        check("valid_rise", int'(valid), 1);
        check("busy_in_done", int'(busy), 0);
        check("value_result", int'(value), exp);
        x_m = 1'b0;
    endtask

    initial begin
        nRST  = 1'b0;
        start = 1'b0;
        x_p   = 1'b0;
        x_m   = 1'b0;
        ready = 1'b0;

        vecs[0] = '{mode: 0, exp:  16};
        vecs[1] = '{mode: 1, exp:   8};
        vecs[2] = '{mode: 2, exp: -16};
        vecs[3] = '{mode: 3, exp:   0};
        vecs[4] = '{mode: 4, exp: -10};
        vecs[5] = '{mode: 5, exp:   8};

        // Reset state
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_value", int'(value), 0);
        nRST = 1'b1;
        tick();
        check("idle_busy", int'(busy), 0);

        // Table-driven windows with immediate handshake
        for (int v = 0; v < 6; v++) begin
            run_window(vecs[v].mode, vecs[v].exp, -1);
            ready = 1'b1;
            tick();
            ready = 1'b0;
            check("hs_valid_drop", int'(valid), 0);
            check("hs_busy_idle", int'(busy), 0);
            check("hs_value_hold", int'(value), vecs[v].exp);
        end

        // Back-pressure: ready low for 5 cycles
        run_window(0, 16, -1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", int'(valid), 1);
            check("bp_value", int'(value), 16);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("bp_valid_drop", int'(valid), 0);
        check("bp_busy", int'(busy), 0);
        tick();
        check("bp_stays_idle", int'(busy), 0);

        // Back-to-back windows: start held, ready high
        ready = 1'b1;
        start = 1'b1;
        tick();
        check("b2b_busy1", int'(busy), 1);
        for (int i = 0; i < WIN; i++) begin
            {x_p, x_m} = 2'b10;
            tick();
        end
        x_p = 1'b1;
        x_m = 1'b0;                              // stale bit before window 2
        tick();
        check("b2b_valid1", int'(valid), 1);
        check("b2b_gap_busy", int'(busy), 0);
        check("b2b_value1", int'(value), 16);
        tick();
        check("b2b_busy2", int'(busy), 1);
        check("b2b_valid_drop", int'(valid), 0);
        check("b2b_value_hold", int'(value), 16);
        for (int i = 0; i < WIN; i++) begin
            {x_p, x_m} = 2'b01;
            if (i == WIN - 1) start = 1'b0;
            tick();
            if (i < WIN - 1) check("b2b_busy_win2", int'(busy), 1);
        end
        x_m = 1'b0;
        tick();
        check("b2b_valid2", int'(valid), 1);
        check("b2b_value2", int'(value), -16);
        tick();
        ready = 1'b0;
        check("b2b_idle_busy", int'(busy), 0);
        check("b2b_idle_valid", int'(valid), 0);

        // Reset mid-window
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            {x_p, x_m} = 2'b10;
            tick();
        end
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        {x_p, x_m} = 2'b00;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(valid), 0);
        check("mid_rst_value", int'(value), 0);
        tick();
        check("mid_rst_idle", int'(busy), 0);
        run_window(0, 16, -1);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // ready toggling in IDLE has no effect
        for (int k = 0; k < 4; k++) begin
            ready = (k % 2 == 0);
            tick();
            check("idle_ready_busy", int'(busy), 0);
            check("idle_ready_valid", int'(valid), 0);
            check("idle_ready_value", int'(value), 16);
        end
        ready = 1'b0;

        // start pulsed mid-window is ignored
        run_window(1, 8, 5);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("pulse_idle_busy", int'(busy), 0);
        check("pulse_idle_valid", int'(valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_stoch_decode

`default_nettype wire
